// File: rtl/fft_bfly_sequencer.sv
// Purpose: control sequencer for a 16-point radix-2 DIT FFT; issues 32 butterfly descriptors (4 stages x 8).
// Latency: START write -> first descriptor valid next cycle; best case DONE 42 cycles after START.
// Backpressure: descriptor held stable while bf_ready=0; a stage begins only after all prior write-backs.
//
// Ports:
//   mclk, puc_rst_n            clock, async active-low reset
//   per_addr/din/en/we, dout   openMSP430 peripheral bus (CTRL at BASE_ADDR, STATUS at BASE_ADDR+1)
//   bf_valid/bf_ready          descriptor handshake; bf_idx_a/b, bf_tw, bf_stage carry the descriptor
//   bf_wb                      one-cycle write-back pulse from the butterfly unit
//   irq                        level interrupt = DONE & IRQ_EN
module fft_bfly_sequencer #(
  parameter logic [13:0] BASE_ADDR = 14'h0090
) (
  input  logic        mclk,
  input  logic        puc_rst_n,
  input  logic [13:0] per_addr,
  input  logic [15:0] per_din,
  input  logic        per_en,
  input  logic [1:0]  per_we,
  output logic [15:0] per_dout,
  output logic        bf_valid,
  input  logic        bf_ready,
  output logic [3:0]  bf_idx_a,
  output logic [3:0]  bf_idx_b,
  output logic [2:0]  bf_tw,
  output logic [1:0]  bf_stage,
  input  logic        bf_wb,
  output logic        irq
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_FINISH} state_t;

  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] tw;
  } desc_t;

  // Butterfly k of stage s: group g = k>>s, position p inside the group.
  function automatic desc_t bfly_desc(input logic [1:0] s, input logic [2:0] k);
    logic [3:0] span;
    logic [3:0] p;
    logic [3:0] g;
    desc_t      d;
    span = 4'd1 << s;
    p    = {1'b0, k} & (span - 4'd1);
    g    = {1'b0, k} >> s;
    d.a  = (g << ({1'b0, s} + 3'd1)) | p;  // p < span, so OR equals g*2*span + p
    d.b  = d.a + span;
    d.tw = 3'(p << (2'd3 - s));
    return d;
  endfunction

  state_t     state_q;
  logic [1:0] stage_q;
  logic [2:0] k_q;
  logic [3:0] outst_q, outst_d;
  logic       irq_en_q, done_q, err_q, err_d;
  logic       bf_valid_q;
  desc_t      bf_desc_q;
  logic [1:0] bf_stage_q;

  logic sel_ctrl, sel_stat, bus_wr, bus_rd, ctrl_wr, stat_wr;
  logic start_cmd, abort_cmd, accept, busy;
  desc_t desc_next_k, desc_next_s;
  logic unused_din;

  assign sel_ctrl  = per_en && (per_addr == BASE_ADDR);
  assign sel_stat  = per_en && (per_addr == BASE_ADDR + 14'd1);
  assign bus_wr    = (per_we == 2'b11);
  assign bus_rd    = (per_we == 2'b00);
  assign ctrl_wr   = sel_ctrl && bus_wr;
  assign stat_wr   = sel_stat && bus_wr;
  assign start_cmd = ctrl_wr && per_din[0];
  assign abort_cmd = ctrl_wr && per_din[2];
  assign accept    = bf_valid_q && bf_ready;
  assign busy      = (state_q != S_IDLE);
  assign unused_din = ^per_din[15:3];

  assign desc_next_k = bfly_desc(stage_q, k_q + 3'd1);
  assign desc_next_s = bfly_desc(stage_q + 2'd1, 3'd0);

  // Outstanding write-backs; a write-back with nothing outstanding is an error.
  always_comb begin
    outst_d = outst_q;
    err_d   = err_q;
    if (stat_wr && per_din[2]) err_d = 1'b0;
    if (accept && !bf_wb) begin
      outst_d = outst_q + 4'd1;
    end else if (!accept && bf_wb) begin
      if (outst_q == 4'd0) err_d = 1'b1;
      else                 outst_d = outst_q - 4'd1;
    end
  end

  always_comb begin
    per_dout = 16'h0000;
    if (bus_rd && sel_ctrl)
      per_dout = {14'b0, irq_en_q, 1'b0};
    else if (bus_rd && sel_stat)
      per_dout = {outst_q, 1'b0, k_q, 2'b00, stage_q, 1'b0, err_q, done_q, busy};
  end

  always_ff @(posedge mclk or negedge puc_rst_n) begin
    if (!puc_rst_n) begin
      state_q    <= S_IDLE;
      stage_q    <= 2'd0;
      k_q        <= 3'd0;
      outst_q    <= 4'd0;
      irq_en_q   <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      bf_valid_q <= 1'b0;
      bf_desc_q  <= '0;
      bf_stage_q <= 2'd0;
    end else begin
      outst_q <= outst_d;
      err_q   <= err_d;
      if (ctrl_wr) irq_en_q <= per_din[1];
      if (stat_wr && per_din[1]) done_q <= 1'b0;

      if (abort_cmd) begin
        // Abort overrides START and everything in flight.
        state_q    <= S_IDLE;
        stage_q    <= 2'd0;
        k_q        <= 3'd0;
        outst_q    <= 4'd0;
        bf_valid_q <= 1'b0;
        bf_desc_q  <= '0;
        bf_stage_q <= 2'd0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (start_cmd) begin
              state_q    <= S_ISSUE;
              stage_q    <= 2'd0;
              k_q        <= 3'd0;
              outst_q    <= 4'd0;
              done_q     <= 1'b0;
              bf_valid_q <= 1'b1;
              bf_desc_q  <= bfly_desc(2'd0, 3'd0);
              bf_stage_q <= 2'd0;
            end
          end
          S_ISSUE: begin
            if (accept) begin
              if (k_q == 3'd7) begin
                k_q        <= 3'd0;
                bf_valid_q <= 1'b0;
                state_q    <= S_DRAIN;
              end else begin
                k_q       <= k_q + 3'd1;
                bf_desc_q <= desc_next_k;
              end
            end
          end
          S_DRAIN: begin
            if (outst_q == 4'd0) begin
              if (stage_q == 2'd3) begin
                state_q <= S_FINISH;
              end else begin
                stage_q    <= stage_q + 2'd1;
                state_q    <= S_ISSUE;
                bf_valid_q <= 1'b1;
                bf_desc_q  <= desc_next_s;
                bf_stage_q <= stage_q + 2'd1;
              end
            end
          end
          S_FINISH: begin
            done_q  <= 1'b1;
            stage_q <= 2'd0;
            state_q <= S_IDLE;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign bf_valid = bf_valid_q;
  assign bf_idx_a = bf_desc_q.a;
  assign bf_idx_b = bf_desc_q.b;
  assign bf_tw    = bf_desc_q.tw;
  assign bf_stage = bf_stage_q;
  assign irq      = done_q && irq_en_q;

endmodule

// File: tb/tb_fft_bfly_sequencer.sv
// Purpose: self-checking bench for fft_bfly_sequencer against a butterfly-schedule reference.
// Latency: checks START latency, best-case DONE cycle, stage barrier and abort/reset timing.
// Backpressure: bf_ready randomised in one run; write-backs scheduled from a delay queue.
module tb_fft_bfly_sequencer;

  localparam logic [13:0] BASE = 14'h0090;
  localparam logic [13:0] STAT = 14'h0091;

  logic        mclk = 1'b0;
  logic        puc_rst_n;
  logic [13:0] per_addr;
  logic [15:0] per_din;
  logic        per_en;
  logic [1:0]  per_we;
  logic [15:0] per_dout;
  logic        bf_valid, bf_ready;
  logic [3:0]  bf_idx_a, bf_idx_b;
  logic [2:0]  bf_tw;
  logic [1:0]  bf_stage;
  logic        bf_wb;
  logic        irq;

  always #5 mclk = ~mclk;

  fft_bfly_sequencer #(.BASE_ADDR(BASE)) dut (
    .mclk(mclk), .puc_rst_n(puc_rst_n),
    .per_addr(per_addr), .per_din(per_din), .per_en(per_en), .per_we(per_we),
    .per_dout(per_dout),
    .bf_valid(bf_valid), .bf_ready(bf_ready),
    .bf_idx_a(bf_idx_a), .bf_idx_b(bf_idx_b), .bf_tw(bf_tw), .bf_stage(bf_stage),
    .bf_wb(bf_wb), .irq(irq)
  );

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference schedule: stage s pairs element j of each 2*span block with j+span, twiddle j*(8/span).
  logic [12:0] exp_desc[32];
  logic [12:0] got_desc[32];
  int   cyc, acc_cnt, wb_cnt;
  int   wb_due[$];
  bit   ready_rand, ready_lvl, inj_wb, hold_chk_en, irq_en_sh;
  int   stage0_delay;
  bit   stalled;
  logic [12:0] stall_desc;

  function automatic logic [12:0] cur_desc();
    return {bf_stage, bf_idx_a, bf_idx_b, bf_tw};
  endfunction

  task automatic build_ref();
    int n = 0;
    for (int s = 0; s < 4; s++) begin
      int span = 1 << s;
      for (int grp = 0; grp < (8 >> s); grp++) begin
        for (int j = 0; j < span; j++) begin
          int a = grp * 2 * span + j;
          exp_desc[n] = {2'(s), 4'(a), 4'(a + span), 3'(j * (8 >> s))};
          n++;
        end
      end
    end
  endtask

  // One clock: log the handshake of the ending cycle, then drive bf_ready/bf_wb for the next.
  task automatic tick();
    int d;
    if (bf_valid && bf_ready) begin
      if (acc_cnt < 32) begin
        got_desc[acc_cnt] = cur_desc();
        check_eq($sformatf("desc%0d", acc_cnt), cur_desc(), exp_desc[acc_cnt]);
      end
      d = (bf_stage == 2'd0 && stage0_delay > 0) ? stage0_delay : 1 + $urandom_range(0, ready_rand ? 2 : 0);
      wb_due.push_back(cyc + d);
      acc_cnt++;
    end
    stalled    = bf_valid && !bf_ready;
    stall_desc = cur_desc();
    @(posedge mclk);
    #1;
    cyc++;
    if (stalled && hold_chk_en) check_eq("stall_hold", {bf_valid, cur_desc()}, {1'b1, stall_desc});
    bf_ready = ready_rand ? 1'($urandom_range(1, 0)) : ready_lvl;
    bf_wb = 1'b0;
    if (inj_wb) begin
      bf_wb  = 1'b1;
      inj_wb = 1'b0;
    end else if (wb_due.size() > 0 && wb_due[0] <= cyc) begin
      bf_wb = 1'b1;
      void'(wb_due.pop_front());
      wb_cnt++;
    end
  endtask

  task automatic set_ready(input bit rnd, input bit lvl);
    ready_rand = rnd;
    ready_lvl  = lvl;
    bf_ready   = rnd ? 1'($urandom_range(1, 0)) : lvl;
  endtask

  task automatic bus_write(input logic [13:0] a, input logic [15:0] d);
    per_addr = a; per_din = d; per_we = 2'b11; per_en = 1'b1;
    tick();
    per_en = 1'b0; per_we = 2'b00; per_din = 16'h0000;
  endtask

  task automatic bus_read(input logic [13:0] a, output logic [15:0] d);
    per_addr = a; per_we = 2'b00; per_en = 1'b1;
    #1;
    d = per_dout;
    per_en = 1'b0;
  endtask

  task automatic start_run();
    acc_cnt = 0;
    wb_cnt  = 0;
    wb_due.delete();
    bus_write(BASE, irq_en_sh ? 16'h0003 : 16'h0001);
  endtask

  task automatic run_to_done(input int t0, input int budget, output int done_at,
                             output logic [15:0] pst, output logic pirq);
    logic [15:0] st;
    done_at = -1;
    pst  = 16'h0000;
    pirq = 1'b0;
    for (int i = 0; i < budget; i++) begin
      bus_read(STAT, st);
      if (st[1]) begin
        done_at = cyc - t0;
        break;
      end
      pst  = st;
      pirq = irq;
      tick();
    end
  endtask

  initial begin
    logic [15:0] st, pst;
    logic        pirq;
    int          done_at, t0, viol;

    build_ref();
    per_addr = '0; per_din = '0; per_en = 1'b0; per_we = 2'b00;
    bf_ready = 1'b0; bf_wb = 1'b0; puc_rst_n = 1'b0;
    ready_rand = 0; ready_lvl = 0; inj_wb = 0; hold_chk_en = 1; irq_en_sh = 0;
    stage0_delay = 0; cyc = 0; acc_cnt = 0; wb_cnt = 0;
    repeat (2) @(posedge mclk);
    #1;
    puc_rst_n = 1'b1;
    tick();

    // Reset state
    check_eq("rst_valid", bf_valid, 1'b0);
    check_eq("rst_desc", cur_desc(), 13'd0);
    check_eq("rst_irq", irq, 1'b0);
    bus_read(STAT, st); check_eq("rst_status", st, 16'h0000);
    bus_read(BASE, st); check_eq("rst_ctrl", st, 16'h0000);
    per_addr = STAT; per_we = 2'b01; per_en = 1'b1; #1;
    check_eq("dout_nonread", per_dout, 16'h0000);
    per_en = 1'b0; per_we = 2'b00;

    // Full best-case run
    set_ready(0, 1);
    t0 = cyc;
    start_run();
    check_eq("start_valid", bf_valid, 1'b1);
    check_eq("start_desc", cur_desc(), {2'd0, 4'd0, 4'd1, 3'd0});
    bus_read(STAT, st); check_eq("start_status", st, 16'h0001);
    run_to_done(t0, 200, done_at, pst, pirq);
    check_eq("full_done_cycle", done_at, 42);
    check_eq("full_finish_busy", pst[1:0], 2'b01);
    bus_read(STAT, st); check_eq("full_status", st, 16'h0002);
    check_eq("full_accepts", acc_cnt, 32);
    check_eq("s0k1", got_desc[1], {2'd0, 4'd2, 4'd3, 3'd0});
    check_eq("s0k7", got_desc[7], {2'd0, 4'd14, 4'd15, 3'd0});
    check_eq("s1k3", got_desc[11], {2'd1, 4'd5, 4'd7, 3'd4});
    check_eq("s2k5", got_desc[21], {2'd2, 4'd9, 4'd13, 3'd2});
    check_eq("s3k7", got_desc[31], {2'd3, 4'd7, 4'd15, 3'd7});
    check_eq("full_irq_off", irq, 1'b0);
    bus_write(STAT, 16'h0002);
    bus_read(STAT, st); check_eq("full_done_clr", st, 16'h0000);

    // Interrupt path
    irq_en_sh = 1;
    bus_write(BASE, 16'h0002);
    bus_read(BASE, st); check_eq("ctrl_irq_en", st, 16'h0002);
    t0 = cyc;
    start_run();
    run_to_done(t0, 200, done_at, pst, pirq);
    check_eq("irq_done_cycle", done_at, 42);
    check_eq("irq_with_done", irq, 1'b1);
    check_eq("irq_prev_low", pirq, 1'b0);
    bus_write(STAT, 16'h0002);
    check_eq("irq_cleared", irq, 1'b0);
    bus_read(STAT, st); check_eq("irq_done_clr", st, 16'h0000);

    // Random backpressure
    set_ready(1, 0);
    t0 = cyc;
    start_run();
    run_to_done(t0, 3000, done_at, pst, pirq);
    check_eq("bp_done_seen", done_at > 0, 1'b1);
    check_eq("bp_accepts", acc_cnt, 32);
    check_eq("bp_wbs", wb_cnt, 32);
    bus_write(STAT, 16'h0002);

    // Stage barrier: stage-0 write-backs delayed 20 cycles
    set_ready(0, 1);
    stage0_delay = 20;
    t0 = cyc;
    start_run();
    for (int i = 0; i < 40 && acc_cnt < 8; i++) tick();
    check_eq("bar_acc", acc_cnt, 8);
    bus_read(STAT, st); check_eq("bar_outst", st, 16'h8001);
    viol = 0;
    for (int i = 0; i < 60 && wb_cnt < 8; i++) begin
      if (bf_valid) viol++;
      tick();
    end
    check_eq("bar_hold", viol, 0);
    check_eq("bar_wait_len", cyc - t0, 28);
    check_eq("bar_valid_wb", bf_valid, 1'b0);
    tick();
    check_eq("bar_valid_drain", bf_valid, 1'b0);
    tick();
    check_eq("bar_resume_valid", bf_valid, 1'b1);
    check_eq("bar_resume_desc", cur_desc(), {2'd1, 4'd0, 4'd2, 3'd0});
    stage0_delay = 0;
    run_to_done(t0, 300, done_at, pst, pirq);
    check_eq("bar_done_seen", done_at > 0, 1'b1);
    bus_write(STAT, 16'h0002);

    // START while busy is ignored
    stage0_delay = 50;
    set_ready(0, 1);
    start_run();
    for (int i = 0; i < 20 && acc_cnt < 3; i++) tick();
    set_ready(0, 0);
    bus_read(STAT, st); check_eq("bsy_before", st, 16'h3301);
    bus_write(BASE, 16'h0003);
    bus_read(STAT, st); check_eq("bsy_after", st, 16'h3301);
    check_eq("bsy_desc", cur_desc(), exp_desc[3]);
    hold_chk_en = 0;
    bus_write(BASE, 16'h0006);
    hold_chk_en = 1;
    wb_due.delete();
    stage0_delay = 0;
    check_eq("bsy_abort_valid", bf_valid, 1'b0);
    bus_read(STAT, st); check_eq("bsy_abort_status", st, 16'h0000);

    // Write-back while idle
    inj_wb = 1;
    tick();
    tick();
    bus_read(STAT, st); check_eq("idle_wb_err", st, 16'h0004);
    bus_write(STAT, 16'h0004);
    bus_read(STAT, st); check_eq("idle_wb_clr", st, 16'h0000);

    // ABORT (with START in the same write) during stage 2
    set_ready(0, 1);
    start_run();
    for (int i = 0; i < 100 && acc_cnt < 19; i++) tick();
    set_ready(0, 0);
    tick();
    bus_read(STAT, st); check_eq("abt_before", st, 16'h0321);
    hold_chk_en = 0;
    bus_write(BASE, 16'h0007);
    hold_chk_en = 1;
    check_eq("abt_valid", bf_valid, 1'b0);
    bus_read(STAT, st); check_eq("abt_status", st, 16'h0000);
    repeat (3) tick();
    check_eq("abt_stay_idle", bf_valid, 1'b0);
    bus_read(STAT, st); check_eq("abt_status_later", st, 16'h0000);

    // Asynchronous reset in DRAIN
    set_ready(0, 1);
    stage0_delay = 20;
    start_run();
    for (int i = 0; i < 40 && acc_cnt < 8; i++) tick();
    tick();
    #2;
    puc_rst_n = 1'b0;
    #1;
    check_eq("arst_valid", bf_valid, 1'b0);
    check_eq("arst_desc", cur_desc(), 13'd0);
    check_eq("arst_irq", irq, 1'b0);
    bus_read(STAT, st); check_eq("arst_status", st, 16'h0000);
    bus_read(BASE, st); check_eq("arst_ctrl", st, 16'h0000);
    wb_due.delete();
    stage0_delay = 0;
    irq_en_sh = 0;
    set_ready(0, 0);
    tick();
    puc_rst_n = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
